// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The requester drives the operands and start; the unit returns the result and status.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, a, b, cin,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, mode, a, b, cin,
        output sum, cout, ovf, busy, done
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Subtraction is a + ~b + 1, so cout=1 means no borrow.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic             accept;
    logic             last_bit;
    logic             xb;
    logic             yb;
    logic             s_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] acc_nxt;

    // One full-adder slice on the bit selected by the counter.
    always_comb begin
        xb       = x_reg[cnt];
        yb       = y_reg[cnt];
        s_bit    = xb ^ yb ^ carry;
        c_nxt    = (xb & yb) | (xb & carry) | (yb & carry);
        last_bit = (cnt == CW'(WIDTH - 1));
        acc_nxt  = acc;
        acc_nxt[cnt] = s_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                // A start held in the completion cycle chains straight into RUN.
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            x_reg  <= '0;
            y_reg  <= '0;
            acc    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            x_reg <= bus.a;
            y_reg <= bus.mode ? ~bus.b : bus.b;
            carry <= bus.mode ? 1'b1 : bus.cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= c_nxt;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                // carry still holds the carry into the MSB at this point.
                sum_r  <= acc_nxt;
                cout_r <= c_nxt;
                ovf_r  <= carry ^ c_nxt;
            end
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled on rising clk.
REQ-005 mode  input  1  0 = add (a+b+cin); 1 = subtract (a-b, two's complement).
REQ-006 a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-007 b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-008 cin  input  1  carry-in for add mode; ignored in subtract mode.
REQ-009 sum  output  WIDTH  registered result of the last completed operation.
REQ-010 cout  output  1  carry out of the MSB; in subtract mode 1 means no borrow.
REQ-011 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  single-cycle pulse when sum/cout/ovf are updated.

Function
REQ-014 Arithmetic SHALL be bit-serial, LSB first, one full-adder step per clock: s = x^y^c, c_next = (x&y)|(x&c)|(y&c).
REQ-015 FSM states SHALL be IDLE, RUN and DONE, with an internal bit counter of ceil(log2(WIDTH)) bits.
REQ-016 IDLE: start=1 SHALL latch a and operand y (b if mode=0, ~b if mode=1) and carry (cin if mode=0, 1 if mode=1), clear the counter, and go to RUN.
REQ-017 RUN: each edge SHALL compute one result bit from bit [counter] into an internal shift register, update carry, and increment the counter.
REQ-018 RUN: on the edge processing bit WIDTH-1, sum/cout/ovf SHALL load together, and the FSM SHALL go to DONE.
REQ-019 Latency: with start accepted at edge 0, results and done SHALL be visible after edge WIDTH.
REQ-020 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-021 DONE: start=1 SHALL begin a new operation as in IDLE (back-to-back); otherwise the FSM SHALL go to IDLE.
REQ-022 start during RUN SHALL be ignored; a, b, cin, mode changes during RUN SHALL NOT affect the result.
REQ-023 sum, cout and ovf SHALL hold the previous result throughout RUN and IDLE until the next completion.
REQ-024 Result width SHALL be exactly WIDTH; carry out of the MSB appears only on cout, with no wrap into sum.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, busy 0, done 0, including mid-RUN; the partial result is discarded.
REQ-026 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where rst_n is high.

Verification (WIDTH=8)
REQ-027 mode=0, a=FF, b=01, cin=0 -> after 8 cycles: sum=00, cout=1, ovf=0, done pulse of 1 cycle.
REQ-028 mode=0, a=7F, b=01, cin=1 -> sum=81, cout=0, ovf=1; busy high for exactly 8 cycles.
REQ-029 mode=1, a=05, b=03, cin=1 -> sum=02, cout=1, ovf=0 (cin ignored); mode=1, a=03, b=05 -> sum=FE, cout=0, ovf=0.
REQ-030 mode=1, a=80, b=01 -> sum=7F, cout=1, ovf=1; a second start held high in the DONE cycle starts the next operation with no IDLE gap.
REQ-031 Pulse rst_n low at cycle 4 of a RUN -> all outputs 0 at once; a new start (a=10, b=20, add) -> sum=30.
REQ-032 Exhaustive check at WIDTH=4 over all a, b, cin and mode against a reference model; start toggled randomly during RUN -> no effect.
